ysyx_25010008_exu: RTL
======================

// Module: ysyx_25010008_exu
// PURPOSE
//  Execute stage between IDU and LSU/WBU. Holds one decoded instruction in a
//  valid/ready pipeline register, drives the ALU from the registered fields and
//  resolves branches and jumps. Emits a one-cycle redirect to IFU/IDU on a taken
//  control transfer and passes the result, rd and memory controls downstream.
// PARAMETERS
//  XLEN    32  datapath width; only 32 is supported.
//  IALIGN  4   instruction alignment in bytes (2 or 4); sets the misaligned-target check.
// PORTS
//  clock           in   1     single clock; all state on posedge
//  reset           in   1     asynchronous, active-high
//  in_valid        in   1     IDU holds a valid uop
//  in_ready        out  1     EXU accepts the uop this cycle
//  in_pc           in   32    instruction PC
//  in_alu_op       in   8     ALU opcode (encoding below)
//  in_src1/in_src2 in   32    ALU operand1/operand2, already muxed by IDU
//  in_imm          in   32    sign-extended immediate
//  in_kind         in   2     0 ALU, 1 BRANCH, 2 JAL, 3 JALR
//  in_rd,in_rd_wen in   5,1   destination register and write enable
//  in_mem_ren/wen  in   1,1   load/store; in_mem_size in 2 (0 B, 1 H, 2 W)
//  in_store_data   in   32    rs2 value for stores
//  out_valid       out  1     result valid toward LSU/WBU
//  out_ready       in   1     downstream accepts
//  out_pc,out_result out 32,32  PC; ALU result, or pc+4 for JAL/JALR
//  out_rd,out_rd_wen out 5,1 ; out_mem_ren/wen/size out 1,1,2 ; out_store_data out 32
//  out_exc         out  1     instruction-address-misaligned on a taken transfer
//  redirect_valid  out  1     one-cycle pulse: fetch must restart at redirect_pc
//  redirect_pc     out  32    redirect target
// BEHAVIOUR
//  Reset: v_q=0, payload regs=0; out_valid, redirect_valid, out_exc read 0.
//  ALU op: op[7:1]==0 -> add (op[0]=1 subtract). With op[0]=1 -> compare, result
//  0/1: b1 eq, b2 ne, b3 ltu, b4 geu, b5 lt, b6 ge. With op[0]=0 -> b1 xor, b2 or,
//  b3 and, b4 sll, b5 srl, b6 sra, b7 ~a&b. Shift amount is src2[4:0].
//  ALU is combinational on registered operands: latency one cycle from in-fire.
//  in_fire=in_valid&in_ready; out_fire=out_valid&out_ready; out_valid=v_q.
//  taken = BRANCH&result[0] | JAL | JALR. target = JALR ? (result & ~1) : pc+imm (mod 2^32).
//  out_result = JAL/JALR ? pc+4 : alu result. rd_wen forced 0 on BRANCH.
//  out_exc = taken & |target[log2(IALIGN)-1:0]; on exc, redirect_valid stays 0,
//  out_rd_wen/mem_ren/mem_wen forced 0 (WBU raises the trap).
//  redirect_valid = out_fire & taken & ~out_exc; redirect_pc=target, same cycle.
//  in_ready = ~v_q | (out_fire & ~redirect_valid). Uop offered in a redirect
//  cycle is wrong-path: not accepted; IDU/IFU flush on the pulse.
//  Update: in_fire loads payload, v_q<=1; else out_fire clears v_q.
//  Simultaneous in_fire & out_fire: back-to-back, one instruction per cycle.
//  Stall: out_valid & ~out_ready -> every out_* and the payload hold stable.
//  Redirect cannot repeat: it only fires on out_fire, which retires the uop.
//  Mid-operation reset: v_q clears immediately (async); pending uop is dropped,
//  no redirect or out_valid is produced for it.
// STRUCTURE
//  Package: ALU op bit positions/named opcodes (ADD,SUB,EQ..GE,XOR..ANDN),
//  kind enum, mem-size enum, XLEN.
//  Single submodule: ysyx_25010008_ALU (opcode, operand1, operand2 -> result).
//  Remainder: payload register, branch/target adders, handshake logic.
// TESTING
//  Reset: assert reset mid-transfer with v_q=1 -> out_valid and redirect_valid 0 next sample.
//  ADD: src1=0x7FFFFFFF, src2=1, op=ADD -> out_result=0x80000000, one cycle after in-fire.
//  BLT: pc=0x80000010, src1=0xFFFFFFFF, src2=1, op=LT, imm=-16 ->
//    redirect_valid pulse with redirect_pc=0x80000000, rd_wen=0, in_ready=0 that cycle.
//  BGEU not taken: src1=1, src2=0xFFFFFFFF -> result 0, no redirect, next uop accepted.
//  JALR: pc=0x80000100, src1=0x80000201, imm=0 -> out_result=0x80000104,
//    redirect_pc=0x80000200; src1=0x80000202 (IALIGN=4) -> out_exc=1, no redirect, rd_wen=0.
//  Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs
//    stable; release -> back-to-back throughput of 1 uop/cycle, order preserved.

Source files
------------

// File: rtl/ysyx_25010008_exu_pkg.sv
// Shared definitions for the execute stage: ALU opcode encoding, uop kinds,
// memory access sizes and the registered uop payload layout.
package ysyx_25010008_exu_pkg;

  localparam int XLEN = 32;

  // One-hot opcode bit positions; bit 0 selects subtract / compare group.
  localparam int BIT_SUB_CMP = 0;
  localparam int BIT_EQ      = 1;
  localparam int BIT_NE      = 2;
  localparam int BIT_LTU     = 3;
  localparam int BIT_GEU     = 4;
  localparam int BIT_LT      = 5;
  localparam int BIT_GE      = 6;
  localparam int BIT_XOR     = 1;
  localparam int BIT_OR      = 2;
  localparam int BIT_AND     = 3;
  localparam int BIT_SLL     = 4;
  localparam int BIT_SRL     = 5;
  localparam int BIT_SRA     = 6;
  localparam int BIT_ANDN    = 7;

  localparam logic [7:0] ALU_ADD  = 8'h00;
  localparam logic [7:0] ALU_SUB  = 8'h01;
  localparam logic [7:0] ALU_EQ   = 8'h03;
  localparam logic [7:0] ALU_NE   = 8'h05;
  localparam logic [7:0] ALU_LTU  = 8'h09;
  localparam logic [7:0] ALU_GEU  = 8'h11;
  localparam logic [7:0] ALU_LT   = 8'h21;
  localparam logic [7:0] ALU_GE   = 8'h41;
  localparam logic [7:0] ALU_XOR  = 8'h02;
  localparam logic [7:0] ALU_OR   = 8'h04;
  localparam logic [7:0] ALU_AND  = 8'h08;
  localparam logic [7:0] ALU_SLL  = 8'h10;
  localparam logic [7:0] ALU_SRL  = 8'h20;
  localparam logic [7:0] ALU_SRA  = 8'h40;
  localparam logic [7:0] ALU_ANDN = 8'h80;

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JAL    = 2'd2,
    KIND_JALR   = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [7:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] imm;
    kind_e           kind;
    logic [4:0]      rd;
    logic            rd_wen;
    logic            mem_ren;
    logic            mem_wen;
    logic [1:0]      mem_size;
    logic [XLEN-1:0] store_data;
  } uop_t;

  function automatic logic is_jump(kind_e k);
    return (k == KIND_JAL) || (k == KIND_JALR);
  endfunction

endpackage

// File: rtl/ysyx_25010008_exu_if.sv
// Bundle of the EXU's upstream (IDU), downstream (LSU/WBU) and redirect signals.
// Handshake: a transfer happens on a cycle where valid & ready are both high; the
// sender holds valid and payload stable until then (a redirect pulse flushes it).
interface ysyx_25010008_exu_if;
  import ysyx_25010008_exu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [7:0]      in_alu_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [XLEN-1:0] in_imm;
  logic [1:0]      in_kind;
  logic [4:0]      in_rd;
  logic            in_rd_wen;
  logic            in_mem_ren;
  logic            in_mem_wen;
  logic [1:0]      in_mem_size;
  logic [XLEN-1:0] in_store_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            out_rd_wen;
  logic            out_mem_ren;
  logic            out_mem_wen;
  logic [1:0]      out_mem_size;
  logic [XLEN-1:0] out_store_data;
  logic            out_exc;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output in_valid, in_pc, in_alu_op, in_src1, in_src2, in_imm, in_kind,
           in_rd, in_rd_wen, in_mem_ren, in_mem_wen, in_mem_size, in_store_data,
           out_ready,
    input  in_ready, out_valid, out_pc, out_result, out_rd, out_rd_wen,
           out_mem_ren, out_mem_wen, out_mem_size, out_store_data, out_exc,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, in_pc, in_alu_op, in_src1, in_src2, in_imm, in_kind,
           in_rd, in_rd_wen, in_mem_ren, in_mem_wen, in_mem_size, in_store_data,
           out_ready,
    output in_ready, out_valid, out_pc, out_result, out_rd, out_rd_wen,
           out_mem_ren, out_mem_wen, out_mem_size, out_store_data, out_exc,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ysyx_25010008_exu_alu.sv
// Combinational ALU: add/sub, six compares producing 0/1, and logic/shift ops,
// selected by a one-hot style opcode with lowest set bit taking priority.
module ysyx_25010008_ALU
  import ysyx_25010008_exu_pkg::*;
(
  input  logic [7:0]      opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            eq;
  logic            ltu;
  logic            lt;
  logic [4:0]      shamt;

  assign sum   = operand1 + operand2;
  assign diff  = operand1 - operand2;
  assign eq    = (operand1 == operand2);
  assign ltu   = (operand1 < operand2);
  assign lt    = ($signed(operand1) < $signed(operand2));
  assign shamt = operand2[4:0];

  always_comb begin
    result = '0;
    if (opcode[7:1] == 7'd0) begin
      result = opcode[BIT_SUB_CMP] ? diff : sum;
    end else if (opcode[BIT_SUB_CMP]) begin
      if      (opcode[BIT_EQ])  result = {{(XLEN-1){1'b0}}, eq};
      else if (opcode[BIT_NE])  result = {{(XLEN-1){1'b0}}, ~eq};
      else if (opcode[BIT_LTU]) result = {{(XLEN-1){1'b0}}, ltu};
      else if (opcode[BIT_GEU]) result = {{(XLEN-1){1'b0}}, ~ltu};
      else if (opcode[BIT_LT])  result = {{(XLEN-1){1'b0}}, lt};
      else if (opcode[BIT_GE])  result = {{(XLEN-1){1'b0}}, ~lt};
    end else begin
      if      (opcode[BIT_XOR])  result = operand1 ^ operand2;
      else if (opcode[BIT_OR])   result = operand1 | operand2;
      else if (opcode[BIT_AND])  result = operand1 & operand2;
      else if (opcode[BIT_SLL])  result = operand1 << shamt;
      else if (opcode[BIT_SRL])  result = operand1 >> shamt;
      else if (opcode[BIT_SRA])  result = $signed(operand1) >>> shamt;
      else if (opcode[BIT_ANDN]) result = ~operand1 & operand2;
    end
  end

endmodule

// File: rtl/ysyx_25010008_exu.sv
// Execute stage: one-entry valid/ready pipeline register feeding the ALU, branch
// and jump resolution, misaligned-target detection and a one-cycle fetch redirect.
module ysyx_25010008_exu
  import ysyx_25010008_exu_pkg::*;
#(
  parameter int IALIGN = 4
) (
  input  logic               clock,
  input  logic               reset,
  ysyx_25010008_exu_if.slave bus
);

  localparam int ALIGN_BITS = (IALIGN == 2) ? 1 : 2;

  logic            v_q;
  uop_t            uop_q;
  uop_t            uop_d;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] target;
  logic            jump;
  logic            taken;
  logic            misaligned;
  logic            exc;
  logic            in_fire;
  logic            out_fire;
  logic            redirect;

  assign uop_d = '{
    pc:         bus.in_pc,
    op:         bus.in_alu_op,
    src1:       bus.in_src1,
    src2:       bus.in_src2,
    imm:        bus.in_imm,
    kind:       kind_e'(bus.in_kind),
    rd:         bus.in_rd,
    rd_wen:     bus.in_rd_wen,
    mem_ren:    bus.in_mem_ren,
    mem_wen:    bus.in_mem_wen,
    mem_size:   bus.in_mem_size,
    store_data: bus.in_store_data
  };

  ysyx_25010008_ALU u_alu (
    .opcode   (uop_q.op),
    .operand1 (uop_q.src1),
    .operand2 (uop_q.src2),
    .result   (alu_result)
  );

  assign seq_pc        = uop_q.pc + 32'd4;
  assign branch_target = uop_q.pc + uop_q.imm;
  assign jump          = is_jump(uop_q.kind);
  assign taken         = jump | ((uop_q.kind == KIND_BRANCH) & alu_result[0]);
  assign target        = (uop_q.kind == KIND_JALR) ? {alu_result[XLEN-1:1], 1'b0}
                                                   : branch_target;
  assign misaligned    = |target[ALIGN_BITS-1:0];
  // Gated by v_q so a retired payload never shows a stale exception.
  assign exc           = v_q & taken & misaligned;

  assign out_fire = v_q & bus.out_ready;
  assign redirect = out_fire & taken & ~misaligned;
  // A uop offered during a redirect is on the wrong path and must not enter.
  assign bus.in_ready = ~v_q | (out_fire & ~redirect);
  assign in_fire      = bus.in_valid & bus.in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q   <= 1'b0;
      uop_q <= '0;
    end else begin
      if (in_fire) begin
        v_q   <= 1'b1;
        uop_q <= uop_d;
      end else if (out_fire) begin
        v_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid      = v_q;
  assign bus.out_pc         = uop_q.pc;
  assign bus.out_result     = jump ? seq_pc : alu_result;
  assign bus.out_rd         = uop_q.rd;
  assign bus.out_rd_wen     = uop_q.rd_wen & (uop_q.kind != KIND_BRANCH) & ~exc;
  assign bus.out_mem_ren    = uop_q.mem_ren & ~exc;
  assign bus.out_mem_wen    = uop_q.mem_wen & ~exc;
  assign bus.out_mem_size   = uop_q.mem_size;
  assign bus.out_store_data = uop_q.store_data;
  assign bus.out_exc        = exc;
  assign bus.redirect_valid = redirect;
  assign bus.redirect_pc    = target;

endmodule
